// File: rtl/placar_varredura_display_if.sv
// Score inputs and display outputs of the scoreboard scan driver.
// The master drives scores and load strobes; the slave drives the display.
interface placar_varredura_display_if;
  logic [3:0] a_dezena;
  logic [3:0] a_unidade;
  logic [3:0] b_dezena;
  logic [3:0] b_unidade;
  logic       carregar;
  logic       blank_lz;
  logic [3:0] anodo;
  logic [6:0] segmentos;
  logic [1:0] digito;
  logic       fim_quadro;

  modport master (
    output a_dezena, a_unidade,
    output b_dezena, b_unidade,
    output carregar, blank_lz,
    input  anodo, segmentos,
    input  digito, fim_quadro
  );

  modport slave (
    input  a_dezena, a_unidade,
    input  b_dezena, b_unidade,
    input  carregar, blank_lz,
    output anodo, segmentos,
    output digito, fim_quadro
  );
endinterface

// File: rtl/placar_varredura_display.sv
// Scan driver for a 4-digit common-anode 7-segment scoreboard display.
// Scores are double-buffered and swapped in only at frame boundaries.
module placar_varredura_display #(
  parameter int CLK_DIV        = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input logic clk,
  input logic reset,
  placar_varredura_display_if.slave bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_ADEZ = 2'd0,
    S_AUNI = 2'd1,
    S_BDEZ = 2'd2,
    S_BUNI = 2'd3
  } slot_t;

  logic [CW-1:0] div_cnt, div_d;
  slot_t         slot, slot_d;
  logic [15:0]   pend, pend_d;
  logic          pend_v, pend_v_d;
  logic [15:0]   shadow, shadow_d;

  logic [15:0] live;
  logic        ultimo;
  logic        fim;
  logic [3:0]  dig;
  logic        lz_slot;
  logic [3:0]  an;
  logic [6:0]  seg_hi;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  assign live   = {bus.a_dezena, bus.a_unidade,
                   bus.b_dezena, bus.b_unidade};
  assign ultimo = (div_cnt == LAST);
  assign fim    = ultimo && (slot == S_BUNI);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      slot    <= S_ADEZ;
      pend    <= '0;
      pend_v  <= 1'b0;
      shadow  <= '0;
    end else begin
      div_cnt <= div_d;
      slot    <= slot_d;
      pend    <= pend_d;
      pend_v  <= pend_v_d;
      shadow  <= shadow_d;
    end
  end

  always_comb begin
    div_d    = div_cnt + 1'b1;
    slot_d   = slot;
    pend_d   = pend;
    pend_v_d = pend_v;
    shadow_d = shadow;
    if (ultimo) begin
      div_d  = '0;
      slot_d = slot_t'(slot + 2'd1);
    end
    // A load landing on the boundary bypasses pend entirely
    if (bus.carregar && fim) begin
      shadow_d = live;
      pend_v_d = 1'b0;
    end else begin
      if (fim && pend_v) begin
        shadow_d = pend;
        pend_v_d = 1'b0;
      end
      if (bus.carregar) begin
        pend_d   = live;
        pend_v_d = 1'b1;
      end
    end
  end

  always_comb begin
    dig     = shadow[15:12];
    an      = 4'b0111;
    lz_slot = 1'b1;
    unique case (slot)
      S_ADEZ: begin
        dig     = shadow[15:12];
        an      = 4'b0111;
        lz_slot = 1'b1;
      end
      S_AUNI: begin
        dig     = shadow[11:8];
        an      = 4'b1011;
        lz_slot = 1'b0;
      end
      S_BDEZ: begin
        dig     = shadow[7:4];
        an      = 4'b1101;
        lz_slot = 1'b1;
      end
      S_BUNI: begin
        dig     = shadow[3:0];
        an      = 4'b1110;
        lz_slot = 1'b0;
      end
    endcase
    seg_hi = dec7(dig);
    // Dead slot start keeps the previous digit from ghosting
    if (div_cnt == '0) begin
      an     = 4'b1111;
      seg_hi = 7'b0000000;
    end else if (bus.blank_lz && lz_slot && dig == 4'd0) begin
      seg_hi = 7'b0000000;
    end
  end

  assign bus.anodo      = an;
  assign bus.segmentos  = ACTIVE_LOW_SEG ? ~seg_hi : seg_hi;
  assign bus.digito     = slot;
  assign bus.fim_quadro = fim;

endmodule

// File: tb/tb_placar_varredura_display.sv
// Directed bench for the scoreboard scan driver.
// Frame table drives the main flow; hand sequences cover boundary load and reset.
module tb_placar_varredura_display;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  placar_varredura_display_if bus ();

  placar_varredura_display #(
    .CLK_DIV(4),
    .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dg;
    int          ld_at;
    logic [15:0] sc;
    logic        blz;
    logic [3:0]  an;
    logic [6:0]  sg;
  } rec_t;

  rec_t tbl [20];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] sc);
    bus.carregar  = ld;
    bus.a_dezena  = sc[15:12];
    bus.a_unidade = sc[11:8];
    bus.b_dezena  = sc[7:4];
    bus.b_unidade = sc[3:0];
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // frame 0: shadow 0000, load 2517 in cycle 5
    tbl[0]  = '{2'd0, -1, 16'h0000, 1'b0, 4'b0111, 7'b0000001};
    tbl[1]  = '{2'd1,  1, 16'h2517, 1'b0, 4'b1011, 7'b0000001};
    tbl[2]  = '{2'd2, -1, 16'h0000, 1'b0, 4'b1101, 7'b0000001};
    tbl[3]  = '{2'd3, -1, 16'h0000, 1'b0, 4'b1110, 7'b0000001};
    // frame 1: shows 2517; 8888 then 2C17 loaded, last wins
    tbl[4]  = '{2'd0,  1, 16'h8888, 1'b0, 4'b0111, 7'b0010010};
    tbl[5]  = '{2'd1, -1, 16'h0000, 1'b0, 4'b1011, 7'b0100100};
    tbl[6]  = '{2'd2,  2, 16'h2C17, 1'b0, 4'b1101, 7'b1001111};
    tbl[7]  = '{2'd3, -1, 16'h0000, 1'b0, 4'b1110, 7'b0001111};
    // frame 2: dash in slot 1; load 0317
    tbl[8]  = '{2'd0,  2, 16'h0317, 1'b0, 4'b0111, 7'b0010010};
    tbl[9]  = '{2'd1, -1, 16'h0000, 1'b0, 4'b1011, 7'b1111110};
    tbl[10] = '{2'd2, -1, 16'h0000, 1'b0, 4'b1101, 7'b1001111};
    tbl[11] = '{2'd3, -1, 16'h0000, 1'b0, 4'b1110, 7'b0001111};
    // frame 3: leading-zero blank on A tens; load 0307
    tbl[12] = '{2'd0, -1, 16'h0000, 1'b1, 4'b0111, 7'b1111111};
    tbl[13] = '{2'd1,  1, 16'h0307, 1'b1, 4'b1011, 7'b0000110};
    tbl[14] = '{2'd2, -1, 16'h0000, 1'b0, 4'b1101, 7'b1001111};
    tbl[15] = '{2'd3, -1, 16'h0000, 1'b0, 4'b1110, 7'b0001111};
    // frame 4: zero shown without blank_lz, blanked in B tens
    tbl[16] = '{2'd0, -1, 16'h0000, 1'b0, 4'b0111, 7'b0000001};
    tbl[17] = '{2'd1, -1, 16'h0000, 1'b0, 4'b1011, 7'b0000110};
    tbl[18] = '{2'd2, -1, 16'h0000, 1'b1, 4'b1101, 7'b1111111};
    tbl[19] = '{2'd3, -1, 16'h0000, 1'b1, 4'b1110, 7'b0001111};

    reset        = 1'b1;
    bus.blank_lz = 1'b0;
    drive(1'b0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_anodo", 32'(bus.anodo), 32'hF);
    chk("rst_seg", 32'(bus.segmentos), 32'h7F);
    chk("rst_digito", 32'(bus.digito), 32'h0);
    chk("rst_fim", 32'(bus.fim_quadro), 32'h0);

    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 4; c++) begin
        bus.blank_lz = tbl[r].blz;
        #1;
        chk($sformatf("an[%0d.%0d]", r, c), 32'(bus.anodo),
            (c == 0) ? 32'hF : 32'(tbl[r].an));
        chk($sformatf("seg[%0d.%0d]", r, c), 32'(bus.segmentos),
            (c == 0) ? 32'h7F : 32'(tbl[r].sg));
        chk($sformatf("dig[%0d.%0d]", r, c), 32'(bus.digito),
            32'(tbl[r].dg));
        chk($sformatf("fim[%0d.%0d]", r, c), 32'(bus.fim_quadro),
            (tbl[r].dg == 2'd3 && c == 3) ? 32'h1 : 32'h0);
        drive(c == tbl[r].ld_at, tbl[r].sc);
        adv(1);
      end
    end
    drive(1'b0, 16'h0000);
    bus.blank_lz = 1'b0;

    // boundary load: stale pend 1111 must never show
    drive(1'b1, 16'h1111);
    adv(1);
    drive(1'b0, 16'h0000);
    adv(14);
    #1;
    chk("bnd_fim", 32'(bus.fim_quadro), 32'h1);
    drive(1'b1, 16'h9999);
    adv(1);
    drive(1'b0, 16'h3333);
    adv(1);
    #1;
    chk("bnd_an", 32'(bus.anodo), 32'h7);
    chk("bnd_seg", 32'(bus.segmentos), 32'h04);
    adv(16);
    #1;
    chk("bnd_next_seg", 32'(bus.segmentos), 32'h04);

    // reset mid-frame with a pending update
    adv(8);
    #1;
    chk("pre_rst_dig", 32'(bus.digito), 32'h2);
    drive(1'b1, 16'h5555);
    adv(1);
    drive(1'b0, 16'h0000);
    reset = 1'b1;
    adv(1);
    #1;
    chk("mrst_dig", 32'(bus.digito), 32'h0);
    chk("mrst_an", 32'(bus.anodo), 32'hF);
    chk("mrst_seg", 32'(bus.segmentos), 32'h7F);
    reset = 1'b0;
    adv(1);
    #1;
    chk("mrst_s0_seg", 32'(bus.segmentos), 32'h01);
    adv(16);
    #1;
    chk("mrst_nf_seg", 32'(bus.segmentos), 32'h01);
    adv(4);
    #1;
    chk("mrst_nf_s1", 32'(bus.segmentos), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
